// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS system: arbiter state encoding,
// default data-memory geometry and an index-width helper.
package mips16_pkg;

  localparam int unsigned MIPS16_DATA_W      = 16;
  localparam int unsigned MIPS16_DMEM_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips16_rr_pick.sv
// Combinational winner select for the data-memory arbiter.
// Default: round-robin search starting at rr_i.
// MIPS16_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, no rr_i port.
module mips16_rr_pick
  import mips16_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
`ifndef MIPS16_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] rr_i,
`endif
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // First requester with req high, scanning from the search origin.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    idx_o   = '0;
    grant_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef MIPS16_ARB_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      cand = IDX_W'((32'(rr_i) + k) % NREQ);
`endif
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mips16_mem_arbiter.sv
// Data-memory arbiter: one single-port synchronous memory shared by NREQ
// req/ack requesters (0 = CPU, 1 = loader/debug). One transaction per grant,
// IDLE -> ISSUE -> RESP. Optional macro MIPS16_ARB_FIXED_PRIO_EN selects
// fixed priority instead of round-robin.
module mips16_mem_arbiter
  import mips16_pkg::*;
#(
  parameter int unsigned ADDR_W = MIPS16_DMEM_ADDR_W,
  parameter int unsigned DATA_W = MIPS16_DATA_W,
  parameter int unsigned NREQ   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy
);

  localparam int unsigned IDX_W = idx_w(NREQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic             we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;

`ifndef MIPS16_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_q, rr_d;
`endif

  mips16_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
`ifndef MIPS16_ARB_FIXED_PRIO_EN
    .rr_i    (rr_q),
`endif
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // State and latched transaction registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef MIPS16_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifndef MIPS16_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Next-state: latch the winner in IDLE, hold through ISSUE, retire in RESP.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef MIPS16_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pick_grant) begin
          g_d     = pick_idx;
          we_d    = req_we[pick_idx];
          addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        rdata_d = we_q ? '0 : mem_rdata;
`ifndef MIPS16_ARB_FIXED_PRIO_EN
        rr_d    = (g_q == IDX_W'(NREQ - 1)) ? '0 : g_q + 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears strobes without waiting a clock;
  // rdata passes memory data through in RESP and holds the last value otherwise.
  always_comb begin
    ack       = '0;
    mem_en    = (state_q == ST_ISSUE);
    mem_we    = (state_q == ST_ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != ST_IDLE);
    rdata     = rdata_q;
    if (state_q == ST_RESP) begin
      ack[g_q] = 1'b1;
      rdata    = we_q ? '0 : mem_rdata;
    end
  end

endmodule

// File: doc/mips16_mem_arbiter.md
Name: mips16_mem_arbiter

Overview:
- Arbitrates one single-port synchronous data memory (256 x 16-bit) between NREQ requesters in the 16-bit single-cycle MIPS system.
- Requester 0 is the CPU data port; requester 1 is the program loader/debug port that writes instruction and data words while the CPU is held in reset.
- Each requester uses a req/ack handshake; the block issues one memory transaction per grant and returns read data with the ack.

Parameters:
- ADDR_W, 8, memory word-address width (256 words).
- DATA_W, 16, data width.
- NREQ, 2, number of requesters (2..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NREQ  per-requester request, level; held until the matching ack.
- req_we  in  NREQ  per-requester write enable (1 = write, 0 = read); stable while req is high.
- req_addr  in  NREQ*ADDR_W  packed word addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data.
- ack  out  NREQ  one-cycle completion pulse per requester.
- rdata  out  DATA_W  read data; valid only in a cycle where ack is high for a read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 (ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy); state IDLE; round-robin pointer rr=0.
- Reset mid-operation: any in-flight transaction is dropped and no ack is produced. mem_en and mem_we go low immediately (asynchronous). Requesters must reissue after reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, select the winner, register its we/addr/wdata and the grant index g, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - mem_en=1, mem_we=latched we, mem_addr and mem_wdata from the latched values.
  - Then go to RESP.
- RESP (one cycle):
  - ack[g]=1; rdata=mem_rdata for reads, rdata=0 for writes.
  - Advance rr to (g+1) mod NREQ.
  - Then go to IDLE.
- Latency: req sampled high in IDLE at edge N gives ack high during cycle N+2. Maximum throughput is one transaction per 3 cycles.
- Arbitration:
  - Round-robin starting at rr; the first requester with req high at or after rr, wrapping, wins.
  - With requests held continuously, grants alternate 0,1,0,1...
- Handshake rules:
  - A requester whose ack is high must drop req, or present a new transaction, on the following cycle.
  - The IDLE cycle after RESP samples fresh req values.
- Protocol violations:
  - req dropped before ack: the latched transaction completes and ack still pulses.
  - Address/data changed while req is high: ignored after latching.
- Only one ack bit is ever high at a time. rdata holds its value between acks.

Optional Feature:
- Macro: MIPS16_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (CPU always beats loader); rr is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Shared package mips16_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2;
  - MIPS16_DATA_W=16 and MIPS16_DMEM_ADDR_W=8, used as parameter defaults.
- One natural sub-module, mips16_rr_pick: combinational winner select from req and rr, outputting a one-hot grant and index. The fixed-priority variant lives inside it under the macro.

Test Plan:
- Reset: hold reset=0 for 100 ns, release -> all outputs 0, busy=0; no mem_en while req=0.
- Single write then read, requester 1: addr 8'h05, wdata 16'h1234 -> mem_en/mem_we=1 one cycle later, ack[1] at +2 cycles. Read of 8'h05 -> ack[1] with rdata=16'h1234.
- Contention: req=2'b11 held, both reads (addr 8'h00 / 8'h01) -> grant order 0,1,0,1; acks 3 cycles apart; never two ack bits high together.
- With MIPS16_ARB_FIXED_PRIO_EN defined, same stimulus -> requester 0 served every transaction while its req stays high; requester 1 starved until req[0]=0.
- Reset mid-transaction: assert reset during ISSUE of a write to 8'h10 -> mem_en/mem_we drop immediately, no ack, state IDLE, rr=0 after release.
- Early req drop: requester 0 reads 8'h03 and drops req in the ISSUE cycle -> ack[0] still pulses with the memory contents of 8'h03.
